// File: rtl/ttl_arb_pkg.sv
// Shared types for the TTL round-robin arbiter: FSM state encoding and
// the index-width helper used to size Grant_idx and the "last owner" register.
package ttl_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ttl_rr_pick.sv
// Combinational rotate-priority picker: first requester with req high,
// searching from last+1 upward and wrapping modulo BLOCKS.
module ttl_rr_pick
   import ttl_arb_pkg::*;
#(
   parameter int BLOCKS = 4,
   parameter int IW     = idx_w(BLOCKS)
) (
   input  logic [BLOCKS-1:0] req_i,
   input  logic [IW-1:0]     last_i,
   output logic [BLOCKS-1:0] gnt_o,
   output logic [IW-1:0]     idx_o,
   output logic              valid_o
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      // Offset BLOCKS brings the search back to last itself, so a lone
      // previous owner can still win when nobody else is asking.
      for (int off = 1; off <= BLOCKS; off++) begin
         cand = IW'((int'(last_i) + off) % BLOCKS);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/ttl_rr_arbiter.sv
// Round-robin ownership arbiter with a guaranteed idle bubble between owners.
// Optional hold timeout compiled in with `define TTL_RR_ARBITER_TIMEOUT_EN.
module ttl_rr_arbiter
   import ttl_arb_pkg::*;
#(
   parameter int BLOCKS     = 4,
   parameter int MAX_HOLD   = 16,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                      Clk,
   input  logic                      Clear,
   input  logic [BLOCKS-1:0]         Req,
   output logic [BLOCKS-1:0]         Grant,
   output logic [idx_w(BLOCKS)-1:0]  Grant_idx,
   output logic                      Busy
);

   localparam int IW = idx_w(BLOCKS);

   // Output delays are back-annotated in timing simulation; zero-delay here.
   if (BLOCKS < 2 || BLOCKS > 8) begin : g_bad_blocks
      $error("ttl_rr_arbiter: BLOCKS must be in 2..8");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("ttl_rr_arbiter: MAX_HOLD must be in 2..255");
   end
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
      $error("ttl_rr_arbiter: output delays must be non-negative");
   end

   arb_state_e          state_q, state_d;
   logic [BLOCKS-1:0]   grant_q, grant_d;
   logic [IW-1:0]       idx_q,   idx_d;
   logic [IW-1:0]       last_q,  last_d;

   logic [BLOCKS-1:0]   pick_gnt;
   logic [IW-1:0]       pick_idx;
   logic                pick_valid;

   ttl_rr_pick #(
      .BLOCKS (BLOCKS),
      .IW     (IW)
   ) u_pick (
      .req_i   (Req),
      .last_i  (last_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

`ifdef TTL_RR_ARBITER_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
   logic [7:0] hold_q, hold_d;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      last_d  = last_q;
`ifdef TTL_RR_ARBITER_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_OWN;
               grant_d = pick_gnt;
               idx_d   = pick_idx;
               last_d  = pick_idx;
`ifdef TTL_RR_ARBITER_TIMEOUT_EN
               hold_d  = 8'd1;
`endif
            end
         end
         ST_OWN: begin
            // Release always passes through IDLE, which yields the bubble cycle.
            if (!Req[idx_q]) begin
               state_d = ST_IDLE;
               grant_d = '0;
               idx_d   = '0;
`ifdef TTL_RR_ARBITER_TIMEOUT_EN
               hold_d  = 8'd0;
            end else if (hold_q == HOLD_MAX) begin
               state_d = ST_IDLE;
               grant_d = '0;
               idx_d   = '0;
               hold_d  = 8'd0;
            end else begin
               hold_d  = hold_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Clear) begin
      if (Clear) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         last_q  <= IW'(BLOCKS - 1);
`ifdef TTL_RR_ARBITER_TIMEOUT_EN
         hold_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
`ifdef TTL_RR_ARBITER_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign Grant     = grant_q;
   assign Grant_idx = idx_q;
   assign Busy      = |grant_q;

endmodule
